// File: rtl/multi_fifo_hs.sv
// Multi-lane FIFO with per-lane valid/ready on push and pop sides.
// Push lanes are compacted in lane order; depth need not be a power of two.
module multi_fifo_hs #(
  parameter int WIDTH     = 32,
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int DEPTH     = 12,
  parameter bit FULL_PASS = 1'b0,
  localparam int CNT_W    = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [M-1:0]            push_valid,
  input  logic [M-1:0][WIDTH-1:0] push_data,
  output logic [M-1:0]            push_ready,
  output logic [N-1:0]            pop_valid,
  output logic [N-1:0][WIDTH-1:0] pop_data,
  input  logic [N-1:0]            pop_ready,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty,
  output logic                    pop_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = CNT_W + 1;
  typedef logic [SUM_W-1:0] sum_t;
  localparam sum_t DEPTH_S = sum_t'(DEPTH);

  // Operands are always < 2*DEPTH, so one conditional subtract suffices.
  function automatic logic [PTR_W-1:0] wrap(input sum_t s);
    sum_t r;
    r = (s >= DEPTH_S) ? s - DEPTH_S : s;
    return r[PTR_W-1:0];
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  sum_t             pops, pushes, space, acc;
  sum_t             rank [M];
  logic             run, pop_bad;

  for (genvar j = 0; j < N; j++) begin : g_pop
    assign pop_valid[j] = sum_t'(j) < sum_t'(count);
    assign pop_data[j]  = pop_valid[j] ? mem[wrap(sum_t'(rptr) + sum_t'(j))] : '0;
  end

  // Only the leading run of ready&valid lanes pops; anything else is a protocol error.
  always_comb begin
    pops    = '0;
    run     = 1'b1;
    pop_bad = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (run && pop_ready[j] && pop_valid[j]) pops = pops + sum_t'(1);
      else begin
        run = 1'b0;
        if (pop_ready[j]) pop_bad = 1'b1;
      end
    end
  end

  assign space = DEPTH_S - sum_t'(count) + (FULL_PASS ? pops : '0);

  always_comb begin
    acc        = '0;
    pushes     = '0;
    push_ready = '0;
    for (int i = 0; i < M; i++) begin
      rank[i]       = acc;
      push_ready[i] = !clear && push_valid[i] && (acc < space);
      if (push_ready[i]) pushes = pushes + sum_t'(1);
      acc = acc + sum_t'(push_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < M; i++)
      if (push_ready[i]) mem[wrap(sum_t'(wptr) + rank[i])] <= push_data[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      pop_err <= 1'b0;
    end else if (clear) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      pop_err <= 1'b0;
    end else begin
      wptr  <= wrap(sum_t'(wptr) + pushes);
      rptr  <= wrap(sum_t'(rptr) + pops);
      count <= CNT_W'(sum_t'(count) + pushes - pops);
      if (pop_bad) pop_err <= 1'b1;
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: tb/tb_multi_fifo_hs.sv
// Directed bench: two M=3/N=2/DEPTH=6 instances, one per FULL_PASS setting, shared stimulus.
module tb_multi_fifo_hs;
  localparam int W = 8, M = 3, N = 2, D = 6, CW = $clog2(D+1);

  logic clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic [M-1:0] push_valid = '0;
  logic [M-1:0][W-1:0] push_data = '0;
  logic [N-1:0] pop_ready = '0;

  logic [M-1:0] pr0, pr1;
  logic [N-1:0] pv0, pv1;
  logic [N-1:0][W-1:0] pd0, pd1;
  logic [CW-1:0] cnt0, cnt1;
  logic full0, full1, empty0, empty1, err0, err1;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  multi_fifo_hs #(.WIDTH(W), .M(M), .N(N), .DEPTH(D), .FULL_PASS(1'b0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .push_valid(push_valid), .push_data(push_data),
    .push_ready(pr0), .pop_valid(pv0), .pop_data(pd0), .pop_ready(pop_ready),
    .count(cnt0), .full(full0), .empty(empty0), .pop_err(err0));

  multi_fifo_hs #(.WIDTH(W), .M(M), .N(N), .DEPTH(D), .FULL_PASS(1'b1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .push_valid(push_valid), .push_data(push_data),
    .push_ready(pr1), .pop_valid(pv1), .pop_data(pd1), .pop_ready(pop_ready),
    .count(cnt1), .full(full1), .empty(empty1), .pop_err(err1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_pvalid", 32'(pv0), 0);
    chk("rst_pdata", 32'(pd0), 0);
    chk("rst_err", 32'(err0), 0);
    push_valid = 3'b101; push_data = 24'hC3BBA1;
    #1 chk("rst_pready", 32'(pr0), 32'b101);
    rst = 1'b0;
    #1 chk("sparse_pready", 32'(pr0), 32'b101);
    tick();
    push_valid = '0;
    chk("sparse_count", 32'(cnt0), 2);
    chk("sparse_pvalid", 32'(pv0), 32'b11);
    chk("sparse_pdata", 32'(pd0), 32'hC3A1);

    push_valid = 3'b111; push_data = 24'h030201;
    tick();
    chk("fill_count", 32'(cnt0), 5);
    push_valid = 3'b111; push_data = 24'h161514;
    #1 chk("one_slot_pr0", 32'(pr0), 32'b001);
    chk("one_slot_pr1", 32'(pr1), 32'b001);
    tick();
    chk("full0", 32'(full0), 1);
    chk("full1_count", 32'(cnt1), 6);
    #1 chk("full_nopop_pr0", 32'(pr0), 0);

    pop_ready = 2'b11; push_valid = 3'b011; push_data = 24'h332221;
    #1 chk("pass_pr1", 32'(pr1), 32'b011);
    chk("nopass_pr0", 32'(pr0), 0);
    tick();
    push_valid = '0;
    chk("pass_count1", 32'(cnt1), 6);
    chk("pass_full1", 32'(full1), 1);
    chk("pass_pdata1", 32'(pd1), 32'h0201);
    chk("nopass_count0", 32'(cnt0), 4);
    chk("nopass_pdata0", 32'(pd0), 32'h0201);
    tick();
    chk("drain_pdata1", 32'(pd1), 32'h1403);
    chk("drain_count1", 32'(cnt1), 4);
    chk("drain_pdata0", 32'(pd0), 32'h1403);
    tick();
    chk("order_pdata1", 32'(pd1), 32'h2221);
    chk("order_count1", 32'(cnt1), 2);
    chk("drain_empty0", 32'(empty0), 1);
    chk("drain_pvalid0", 32'(pv0), 0);
    chk("no_err1", 32'(err1), 0);

    pop_ready = 2'b10;
    tick();
    chk("gap_count1", 32'(cnt1), 2);
    chk("gap_err1", 32'(err1), 1);
    chk("invalid_err0", 32'(err0), 1);
    pop_ready = '0;
    tick();
    chk("sticky_err1", 32'(err1), 1);

    clear = 1'b1; push_valid = 3'b111; pop_ready = 2'b11;
    #1 chk("clear_pr0", 32'(pr0), 0);
    chk("clear_pr1", 32'(pr1), 0);
    tick();
    clear = 1'b0; push_valid = '0; pop_ready = '0;
    chk("clear_count1", 32'(cnt1), 0);
    chk("clear_empty1", 32'(empty1), 1);
    chk("clear_err1", 32'(err1), 0);
    chk("clear_err0", 32'(err0), 0);

    // walk both pointers to slot 5 with the FIFO empty
    push_valid = 3'b111; push_data = 24'h0C0B0A;
    tick();
    push_valid = 3'b011; push_data = 24'h000E0D; pop_ready = 2'b11;
    #1 chk("mixed_pr0", 32'(pr0), 32'b011);
    tick();
    push_valid = '0;
    chk("mixed_pdata0", 32'(pd0), 32'h0D0C);
    tick();
    pop_ready = 2'b01;
    chk("mixed_last", 32'(pd0), 32'h000E);
    tick();
    pop_ready = '0;
    chk("pre_wrap_empty", 32'(empty0), 1);

    push_valid = 3'b111; push_data = 24'h5A5958;
    #1 chk("wrap_pr0", 32'(pr0), 32'b111);
    tick();
    push_valid = '0;
    chk("wrap_count", 32'(cnt0), 3);
    chk("wrap_pdata", 32'(pd0), 32'h5958);
    pop_ready = 2'b11;
    tick();
    pop_ready = '0;
    chk("wrap_pop_count", 32'(cnt0), 1);
    chk("wrap_pop_pvalid", 32'(pv0), 32'b01);
    chk("wrap_pop_pdata", 32'(pd0), 32'h005A);
    chk("wrap_pop_pdata1", 32'(pd1), 32'h005A);

    #2 rst = 1'b1;
    #1 chk("midrst_count", 32'(cnt0), 0);
    chk("midrst_empty", 32'(empty1), 1);
    chk("midrst_pdata", 32'(pd0), 0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
